// File: rtl/pipe_pkg.sv
// Shared types and helpers for the MEM/WB pipeline record buffer.
//   wb_rec_t   : write-back record at default widths
//   ptr_inc    : circular pointer increment with explicit wrap (any depth 1..16)
package pipe_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned PTR_MAX_W      = 4;

  typedef struct packed {
    logic                      wb_en;
    logic                      mem_r_en;
    logic [DATA_W_DEF-1:0]     alu_result;
    logic [DATA_W_DEF-1:0]     mem_read_value;
    logic [REG_ADDR_W_DEF-1:0] dst;
  } wb_rec_t;

  // Wraps from depth-1 back to 0; depth need not be a power of two.
  function automatic logic [PTR_MAX_W-1:0] ptr_inc(input logic [PTR_MAX_W-1:0] ptr,
                                                   input int unsigned          depth);
    if (ptr >= PTR_MAX_W'(depth - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = ptr + PTR_MAX_W'(1);
    end
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Occupancy/pointer control for the MEM/WB record buffer, payload independent.
// Ports:
//   clk, rst (sync, active-low), flush
//   in_valid, out_ready       : handshake inputs
//   in_ready, out_valid       : handshake outputs (in_ready combinational from out_ready)
//   push                      : record is written this cycle at wr_ptr
//   wr_ptr, rd_ptr, count     : buffer state
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             push,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rdy_q, rdy_d;
  logic             pop;

  // Handshake decode and next-state computation.
  always_comb begin
    // rdy_q holds in_ready low for the first cycle after reset release.
    in_ready  = rst & rdy_q & ~flush & ((count_q < CNT_W'(DEPTH)) | out_ready);
    out_valid = (count_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready & ~flush;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    rdy_d    = 1'b1;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = PTR_W'(ptr_inc(PTR_MAX_W'(wr_ptr_q), DEPTH));
      if (pop)  rd_ptr_d = PTR_W'(ptr_inc(PTR_MAX_W'(rd_ptr_q), DEPTH));
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rdy_q    <= rdy_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/mem_wb_pipe_fifo.sv
// MEM/WB pipeline stage buffer holding up to DEPTH write-back records with
// valid/ready handshakes on both sides and a synchronous flush.
// Ports:
//   clk, rst (sync, active-low), flush
//   in_valid/in_ready + *_in         : record from MEM
//   out_valid/out_ready + head fields: record to WB, zeroed when out_valid==0
//   count                            : occupancy 0..DEPTH
//   stall_cycles                     : only with MEM_WB_STALL_CNT_EN defined; saturating
//                                      count of stalled handshake sides
module mem_wb_pipe_fifo
  import pipe_pkg::*;
#(
  parameter  int unsigned DATA_W     = DATA_W_DEF,
  parameter  int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter  int unsigned DEPTH      = 2,
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     mem_read_value_in,
  input  logic [REG_ADDR_W-1:0] dst_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  wb_en,
  output logic                  mem_r_en,
  output logic [DATA_W-1:0]     alu_result,
  output logic [DATA_W-1:0]     mem_read_value,
  output logic [REG_ADDR_W-1:0] dst,
  output logic [CNT_W-1:0]      count
`ifdef MEM_WB_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     mem_read_value;
    logic [REG_ADDR_W-1:0] dst;
  } rec_t;

  logic             push;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  rec_t             in_rec;
  rec_t             head;
  rec_t             mem_q [DEPTH];
  rec_t             mem_d [DEPTH];

  pipe_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .push      (push),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count)
  );

  // Storage write port.
  always_comb begin
    in_rec.wb_en          = wb_en_in;
    in_rec.mem_r_en       = mem_r_en_in;
    in_rec.alu_result     = alu_result_in;
    in_rec.mem_read_value = mem_read_value_in;
    in_rec.dst            = dst_in;
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = in_rec;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Head record, gated so an empty buffer can never cause a register-file write.
  always_comb begin
    head           = mem_q[rd_ptr];
    wb_en          = out_valid & head.wb_en;
    mem_r_en       = out_valid & head.mem_r_en;
    alu_result     = out_valid ? head.alu_result     : '0;
    mem_read_value = out_valid ? head.mem_read_value : '0;
    dst            = out_valid ? head.dst            : '0;
  end

`ifdef MEM_WB_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [1:0]  stall_inc;

  // Each stalled side contributes one per cycle; saturates at all-ones.
  always_comb begin
    stall_inc = 2'(out_valid & ~out_ready) + 2'(in_valid & ~in_ready);
    if (stall_q > (32'hFFFF_FFFF - 32'(stall_inc))) begin
      stall_d = 32'hFFFF_FFFF;
    end else begin
      stall_d = stall_q + 32'(stall_inc);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_fifo.sv
// Bench for mem_wb_pipe_fifo: three instances (DEPTH 1, 2, 3) share one input
// stream; a queue-per-instance model predicts every output.
module tb_mem_wb_pipe_fifo;
  import pipe_pkg::*;

  localparam int NI = 3;  // instance i has DEPTH i+1

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, wb_en_in, mem_r_en_in;
  logic [31:0] alu_in, mrv_in;
  logic [4:0]  dst_in;

  logic        ir [NI];
  logic        ov [NI];
  logic        wbo [NI];
  logic        mro [NI];
  logic [31:0] alu_o [NI];
  logic [31:0] mrv_o [NI];
  logic [4:0]  dst_o [NI];
  logic [1:0]  cnt_o [NI];
  logic [31:0] stall_o [NI];

  wb_rec_t     mq [NI][$];
  bit          rdy_m = 1'b0;
  longint      stall_m [NI];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned D = g + 1;
    logic [$clog2(D+1)-1:0] c;
    mem_wb_pipe_fifo #(.DATA_W(32), .REG_ADDR_W(5), .DEPTH(D)) u_dut (
      .clk               (clk),
      .rst               (rst),
      .flush             (flush),
      .in_valid          (in_valid),
      .in_ready          (ir[g]),
      .wb_en_in          (wb_en_in),
      .mem_r_en_in       (mem_r_en_in),
      .alu_result_in     (alu_in),
      .mem_read_value_in (mrv_in),
      .dst_in            (dst_in),
      .out_valid         (ov[g]),
      .out_ready         (out_ready),
      .wb_en             (wbo[g]),
      .mem_r_en          (mro[g]),
      .alu_result        (alu_o[g]),
      .mem_read_value    (mrv_o[g]),
      .dst               (dst_o[g]),
      .count             (c)
`ifdef MEM_WB_STALL_CNT_EN
      ,
      .stall_cycles      (stall_o[g])
`endif
    );
    assign cnt_o[g] = 2'(c);
`ifndef MEM_WB_STALL_CNT_EN
    assign stall_o[g] = '0;
`endif
  end

  // Model: expected in_ready from buffer occupancy and the handshake rules.
  function automatic bit exp_ir(int i);
    return (rst === 1'b1) && rdy_m && (flush !== 1'b1) &&
           ((mq[i].size() < i + 1) || (out_ready === 1'b1));
  endfunction

  task automatic set_rec(input logic we, input logic mr, input logic [31:0] a,
                         input logic [31:0] m, input logic [4:0] d);
    wb_en_in = we; mem_r_en_in = mr; alu_in = a; mrv_in = m; dst_in = d;
  endtask

  // Advance the model by one clock edge using the current inputs, then the clock.
  task automatic tick();
    wb_rec_t r;
    r.wb_en = wb_en_in; r.mem_r_en = mem_r_en_in; r.alu_result = alu_in;
    r.mem_read_value = mrv_in; r.dst = dst_in;
    for (int i = 0; i < NI; i++) begin
      bit irx, ovx;
      longint inc;
      irx = exp_ir(i);
      ovx = mq[i].size() != 0;
      inc = ((ovx && !out_ready) ? 1 : 0) + ((in_valid && !irx) ? 1 : 0);
      if (!rst) stall_m[i] = 0;
      else stall_m[i] = (stall_m[i] + inc > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : stall_m[i] + inc;
      if (!rst || flush) begin
        mq[i].delete();
      end else begin
        if (ovx && out_ready) void'(mq[i].pop_front());
        if (in_valid && irx) mq[i].push_back(r);
      end
    end
    rdy_m = (rst === 1'b1);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    set_rec(1'b1, 1'b1, 32'hAAAA_5555, 32'h1234_5678, 5'd7);
    tick(); tick();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({ir[i], ov[i], wbo[i], mro[i], alu_o[i], mrv_o[i], dst_o[i], cnt_o[i]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs d=%0d got ir=%b ov=%b wb=%b mr=%b alu=%h mrv=%h dst=%0d cnt=%0d, want all 0",
                 i + 1, ir[i], ov[i], wbo[i], mro[i], alu_o[i], mrv_o[i], dst_o[i], cnt_o[i]);
      end
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (ir[i] !== 1'b0) begin
        errors++;
        $display("FAIL release_cycle_in_ready d=%0d got %b want 0", i + 1, ir[i]);
      end
    end
    tick();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (ir[i] !== 1'b1 || ov[i] !== 1'b0 || cnt_o[i] !== 2'd0) begin
        errors++;
        $display("FAIL after_release d=%0d got ir=%b ov=%b cnt=%0d want ir=1 ov=0 cnt=0",
                 i + 1, ir[i], ov[i], cnt_o[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain();
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tick();
    flush = 1'b0;
    in_valid = 1'b1; set_rec(1'b1, 1'b0, 32'h10, 32'h0, 5'd3); tick();
    set_rec(1'b1, 1'b0, 32'h20, 32'h0, 5'd4); tick();
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 1; i < NI; i++) begin
        checks++;
        if (cnt_o[i] !== 2'd2 || ov[i] !== 1'b1 || wbo[i] !== 1'b1 || alu_o[i] !== 32'h10 ||
            dst_o[i] !== 5'd3 || (i == 1 && ir[i] !== 1'b0)) begin
          errors++;
          $display("FAIL full_hold_A d=%0d k=%0d got cnt=%0d ov=%b wb=%b alu=%h dst=%0d ir=%b want cnt=2 ov=1 wb=1 alu=10 dst=3",
                   i + 1, k, cnt_o[i], ov[i], wbo[i], alu_o[i], dst_o[i], ir[i]);
        end
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      logic        exp_v;
      logic [31:0] exp_a;
      logic [4:0]  exp_d;
      exp_v = (k < 2);
      exp_a = (k == 0) ? 32'h10 : (k == 1) ? 32'h20 : 32'h0;
      exp_d = (k == 0) ? 5'd3 : (k == 1) ? 5'd4 : 5'd0;
      for (int i = 1; i < NI; i++) begin
        checks++;
        if (ov[i] !== exp_v || wbo[i] !== exp_v || alu_o[i] !== exp_a || dst_o[i] !== exp_d) begin
          errors++;
          $display("FAIL drain d=%0d k=%0d got ov=%b wb=%b alu=%h dst=%0d want ov=%b wb=%b alu=%h dst=%0d",
                   i + 1, k, ov[i], wbo[i], alu_o[i], dst_o[i], exp_v, exp_v, exp_a, exp_d);
        end
      end
      tick();
    end
  endtask

  task automatic test_full_stream();
    logic [31:0] seq [6];
    seq = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60};
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tick();
    flush = 1'b0; in_valid = 1'b1;
    set_rec(1'b1, 1'b0, 32'h10, 32'h0, 5'd3); tick();
    set_rec(1'b1, 1'b0, 32'h20, 32'h0, 5'd4); tick();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [1:0] exp_c;
      in_valid = (k < 4);
      set_rec(1'b1, 1'b0, 32'h30 + 32'(k) * 32'h10, 32'h0, 5'(5 + k));
      #1;
      exp_c = (k < 5) ? 2'd2 : 2'd1;
      for (int i = 1; i < NI; i++) begin
        checks++;
        if (cnt_o[i] !== exp_c || ov[i] !== 1'b1 || alu_o[i] !== seq[k] ||
            (k < 4 && ir[i] !== 1'b1)) begin
          errors++;
          $display("FAIL stream d=%0d k=%0d got cnt=%0d ov=%b alu=%h ir=%b want cnt=%0d ov=1 alu=%h",
                   i + 1, k, cnt_o[i], ov[i], alu_o[i], ir[i], exp_c, seq[k]);
        end
      end
      tick();
    end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || cnt_o[i] !== 2'd0) begin
        errors++;
        $display("FAIL stream_empty d=%0d got ov=%b cnt=%0d want 0 0", i + 1, ov[i], cnt_o[i]);
      end
    end
  endtask

  task automatic test_flush();
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    set_rec(1'b1, 1'b0, 32'hA, 32'h0, 5'd1); tick();
    set_rec(1'b1, 1'b0, 32'hB, 32'h0, 5'd2); tick();
    flush = 1'b1; out_ready = 1'b1;
    set_rec(1'b1, 1'b1, 32'h77, 32'h88, 5'd9);
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (ir[i] !== 1'b0) begin
        errors++;
        $display("FAIL flush_in_ready d=%0d got %b want 0", i + 1, ir[i]);
      end
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({ov[i], wbo[i], mro[i], alu_o[i], mrv_o[i], dst_o[i], cnt_o[i]} !== '0) begin
          errors++;
          $display("FAIL after_flush d=%0d k=%0d got ov=%b wb=%b alu=%h mrv=%h dst=%0d cnt=%0d want all 0",
                   i + 1, k, ov[i], wbo[i], alu_o[i], mrv_o[i], dst_o[i], cnt_o[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_depth1_stream();
    int delivered = 0;
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b1; tick();
    flush = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = (k < 8);
      set_rec(1'b1, 1'b1, 32'(k), 32'hDEAD_0000 + 32'(k), 5'(k + 1));
      #1;
      checks++;
      if (k == 0 || k == 9) begin
        if (ov[0] !== 1'b0) begin
          errors++;
          $display("FAIL d1_idle k=%0d got ov=%b want 0", k, ov[0]);
        end
      end else if (ov[0] !== 1'b1 || mro[0] !== 1'b1 || mrv_o[0] !== 32'hDEAD_0000 + 32'(k - 1) ||
                   (k < 8 && ir[0] !== 1'b1)) begin
        errors++;
        $display("FAIL d1_stream k=%0d got ov=%b mr=%b mrv=%h ir=%b want ov=1 mr=1 mrv=%h ir=1",
                 k, ov[0], mro[0], mrv_o[0], ir[0], 32'hDEAD_0000 + 32'(k - 1));
      end else begin
        delivered++;
      end
      tick();
    end
    checks++;
    if (delivered != 8) begin
      errors++;
      $display("FAIL d1_delivered got %0d want 8", delivered);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst       = ($urandom_range(0, 99) >= 1);
      flush     = ($urandom_range(0, 99) < 3);
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      set_rec(1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
      #1;
      for (int i = 0; i < NI; i++) begin
        wb_rec_t     h;
        logic [74:0] exp_v, got_v;
        h = (mq[i].size() != 0) ? mq[i][0] : '0;
        exp_v = {exp_ir(i), mq[i].size() != 0, h.wb_en, h.mem_r_en, h.alu_result,
                 h.mem_read_value, h.dst, 2'(mq[i].size())};
        got_v = {ir[i], ov[i], wbo[i], mro[i], alu_o[i], mrv_o[i], dst_o[i], cnt_o[i]};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL random d=%0d cyc=%0d got=%h want=%h", i + 1, cyc, got_v, exp_v);
        end
`ifdef MEM_WB_STALL_CNT_EN
        checks++;
        if (stall_o[i] !== 32'(stall_m[i])) begin
          errors++;
          $display("FAIL random_stall d=%0d cyc=%0d got=%0d want=%0d", i + 1, cyc, stall_o[i], stall_m[i]);
        end
`endif
      end
      tick();
    end
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
  endtask

`ifdef MEM_WB_STALL_CNT_EN
  task automatic test_stall();
    longint base;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    rst = 1'b1; tick();
    checks++;
    if (stall_o[1] !== 32'd0) begin
      errors++;
      $display("FAIL stall_reset got %0d want 0", stall_o[1]);
    end
    out_ready = 1'b0; in_valid = 1'b1;
    set_rec(1'b1, 1'b0, 32'h1, 32'h0, 5'd1); tick();
    set_rec(1'b1, 1'b0, 32'h2, 32'h0, 5'd2); tick();
    base = stall_m[1];
    repeat (5) tick();
    checks++;
    if (stall_o[1] !== 32'(base + 10)) begin
      errors++;
      $display("FAIL stall_count got %0d want %0d", stall_o[1], base + 10);
    end
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; tick();
    flush = 1'b0;
    checks++;
    if (stall_o[1] !== 32'(base + 10)) begin
      errors++;
      $display("FAIL stall_after_flush got %0d want %0d", stall_o[1], base + 10);
    end
    rst = 1'b0; tick();
    rst = 1'b1;
    checks++;
    if (stall_o[1] !== 32'd0) begin
      errors++;
      $display("FAIL stall_after_reset got %0d want 0", stall_o[1]);
    end
    tick();
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_rec(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < NI; i++) stall_m[i] = 0;
    @(negedge clk);
    #1;
    test_reset();
    test_fill_drain();
    test_full_stream();
    test_flush();
    test_depth1_stream();
    test_random();
`ifdef MEM_WB_STALL_CNT_EN
    test_stall();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
